// File: rtl/updown_counter_bank.sv
// Bank of CHANNELS independent WIDTH-bit up/down counters with modulo limit.
// Each channel has its own enable, direction, synchronous load, terminal-count
// pulse and sticky wrap flag. With limit = all-ones and SATURATE = 0 a channel
// behaves as a plain free-running counter.
//
// Ports (channel i uses bit i of 1-bit buses, bits [i*WIDTH +: WIDTH] of wide buses):
//   clk       rising-edge clock
//   reset     synchronous active-high reset, clears all state
//   en        per-channel count enable
//   dir       per-channel direction, 1 = up, 0 = down
//   load      per-channel synchronous load strobe (overrides en)
//   load_val  value loaded, clamped to limit
//   limit     upper bound of the count range 0..limit, sampled every cycle
//   clr_flag  per-channel clear of the sticky wrapped flag
//   count     registered count value
//   tc        registered one-cycle terminal-count pulse
//   wrapped   registered sticky terminal-event flag
module updown_counter_bank #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned SATURATE = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       dir,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_val,
   input  logic [CHANNELS*WIDTH-1:0] limit,
   input  logic [CHANNELS-1:0]       clr_flag,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       tc,
   output logic [CHANNELS-1:0]       wrapped
);

   localparam bit SAT = (SATURATE != 0);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] count_q, count_d;
      logic [WIDTH-1:0] lim, lval;
      logic             tc_q, tc_d;
      logic             wrapped_q, wrapped_d;

      assign lim  = limit[i*WIDTH +: WIDTH];
      assign lval = load_val[i*WIDTH +: WIDTH];

      // Next-state: load beats count enable; terminal events raise tc_d.
      always_comb begin
         count_d = count_q;
         tc_d    = 1'b0;
         if (load[i]) begin
            count_d = (lval > lim) ? lim : lval;
         end else if (en[i]) begin
            if (dir[i]) begin
               // ">=" also catches a count left above a freshly lowered limit.
               if (count_q < lim) begin
                  count_d = count_q + WIDTH'(1);
               end else begin
                  tc_d    = 1'b1;
                  count_d = SAT ? lim : '0;
               end
            end else begin
               // Counting down from above the limit decrements normally.
               if (count_q != '0) begin
                  count_d = count_q - WIDTH'(1);
               end else begin
                  tc_d    = 1'b1;
                  count_d = SAT ? '0 : lim;
               end
            end
         end
         // A terminal event wins over a simultaneous clear.
         wrapped_d = tc_d | (wrapped_q & ~clr_flag[i]);
      end

      // State registers with synchronous reset.
      always_ff @(posedge clk) begin
         if (reset) begin
            count_q   <= '0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
         end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
         end
      end

      assign count[i*WIDTH +: WIDTH] = count_q;
      assign tc[i]                   = tc_q;
      assign wrapped[i]              = wrapped_q;
   end

endmodule

// File: tb/tb_updown_counter_bank.sv
// Directed bench: vector table for a wrapping bank, hand sequence for a saturating bank.
module tb_updown_counter_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Wrapping instance (SATURATE = 0)
   logic        a_reset;
   logic [1:0]  a_en, a_dir, a_load, a_clr;
   logic [15:0] a_lv, a_lim, a_count;
   logic [1:0]  a_tc, a_wr;

   updown_counter_bank #(.WIDTH(8), .CHANNELS(2), .SATURATE(0)) dut_a (
      .clk(clk), .reset(a_reset), .en(a_en), .dir(a_dir), .load(a_load),
      .load_val(a_lv), .limit(a_lim), .clr_flag(a_clr),
      .count(a_count), .tc(a_tc), .wrapped(a_wr)
   );

   // Saturating instance (SATURATE = 1)
   logic        b_reset;
   logic [1:0]  b_en, b_dir, b_load, b_clr;
   logic [15:0] b_lv, b_lim, b_count;
   logic [1:0]  b_tc, b_wr;

   updown_counter_bank #(.WIDTH(8), .CHANNELS(2), .SATURATE(1)) dut_b (
      .clk(clk), .reset(b_reset), .en(b_en), .dir(b_dir), .load(b_load),
      .load_val(b_lv), .limit(b_lim), .clr_flag(b_clr),
      .count(b_count), .tc(b_tc), .wrapped(b_wr)
   );

   typedef struct {
      logic       rst;
      logic [1:0] en, dir, ld;
      logic [7:0] lv0, lv1, lim0, lim1;
      logic [1:0] clr;
      logic [7:0] c0, c1;
      logic [1:0] tc, wr;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mkv(logic rst, logic [1:0] en, logic [1:0] dir, logic [1:0] ld,
                                logic [7:0] lv0, logic [7:0] lv1, logic [7:0] lim0,
                                logic [7:0] lim1, logic [1:0] clr, logic [7:0] c0,
                                logic [7:0] c1, logic [1:0] tc, logic [1:0] wr);
      vec_t v;
      v.rst = rst; v.en = en; v.dir = dir; v.ld = ld;
      v.lv0 = lv0; v.lv1 = lv1; v.lim0 = lim0; v.lim1 = lim1; v.clr = clr;
      v.c0 = c0; v.c1 = c1; v.tc = tc; v.wr = wr;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, idx, act, act, exp, exp);
      end
   endtask

   // One saturating-bank step on channel 0; channel 1 idle.
   task automatic b_step(input int idx, input logic rst, input logic en, input logic dir,
                         input logic ld, input logic [7:0] lv, input logic [7:0] lim,
                         input logic clr, input logic [7:0] ec, input logic etc,
                         input logic ewr);
      b_reset = rst; b_en = {1'b0, en}; b_dir = {1'b0, dir}; b_load = {1'b0, ld};
      b_lv = {8'd0, lv}; b_lim = {8'd255, lim}; b_clr = {1'b0, clr};
      @(posedge clk); #1;
      chk("sat_count", idx, b_count[7:0], ec);
      chk("sat_tc",    idx, {7'd0, b_tc[0]}, {7'd0, etc});
      chk("sat_wrap",  idx, {7'd0, b_wr[0]}, {7'd0, ewr});
      chk("sat_ch1_idle", idx, b_count[15:8], 8'd0);
   endtask

   initial begin
      a_reset = 1'b1; a_en = '0; a_dir = '0; a_load = '0; a_clr = '0; a_lv = '0; a_lim = '1;
      b_reset = 1'b1; b_en = '0; b_dir = '0; b_load = '0; b_clr = '0; b_lv = '0; b_lim = '1;

      // Reset held with en = 1, then ch0 up / ch1 down over the full range
      for (int k = 0; k < 3; k++)
         vecs.push_back(mkv(1, 2'b11, 2'b01, 2'b00, 0, 0, 255, 255, 2'b00, 0, 0, 2'b00, 2'b00));
      vecs.push_back(mkv(0, 2'b11, 2'b01, 2'b00, 0, 0, 255, 255, 2'b00, 1, 255, 2'b10, 2'b10));
      vecs.push_back(mkv(0, 2'b11, 2'b01, 2'b00, 0, 0, 255, 255, 2'b00, 2, 254, 2'b00, 2'b10));
      vecs.push_back(mkv(0, 2'b11, 2'b01, 2'b00, 0, 0, 255, 255, 2'b00, 3, 253, 2'b00, 2'b10));
      // Load ch0 = 0 with limit 9, clear ch1 flag
      vecs.push_back(mkv(0, 2'b01, 2'b01, 2'b01, 0, 0, 9, 255, 2'b10, 0, 253, 2'b00, 2'b00));
      // Modulo-10 wrap over 12 enabled cycles
      for (int k = 1; k <= 12; k++)
         vecs.push_back(mkv(0, 2'b01, 2'b01, 2'b00, 0, 0, 9, 255, 2'b00,
                            8'((k <= 9) ? k : k - 10), 253,
                            (k == 10) ? 2'b01 : 2'b00, (k >= 10) ? 2'b01 : 2'b00));
      // Load priority and clamp to limit
      vecs.push_back(mkv(0, 2'b01, 2'b01, 2'b01, 200, 0, 100, 255, 2'b00, 100, 253, 2'b00, 2'b01));
      // Terminal event with clr_flag: set wins
      vecs.push_back(mkv(0, 2'b01, 2'b01, 2'b00, 0, 0, 100, 255, 2'b01, 0, 253, 2'b01, 2'b01));
      // clr_flag alone clears, en = 0 holds
      vecs.push_back(mkv(0, 2'b00, 2'b01, 2'b00, 0, 0, 100, 255, 2'b01, 0, 253, 2'b00, 2'b00));
      // Limit shrink below count, counting up
      vecs.push_back(mkv(0, 2'b00, 2'b01, 2'b11, 50, 7, 255, 255, 2'b00, 50, 7, 2'b00, 2'b00));
      vecs.push_back(mkv(0, 2'b01, 2'b01, 2'b00, 0, 0, 20, 255, 2'b00, 0, 7, 2'b01, 2'b01));
      // Limit shrink below count, counting down
      vecs.push_back(mkv(0, 2'b00, 2'b01, 2'b11, 50, 7, 255, 255, 2'b00, 50, 7, 2'b00, 2'b01));
      vecs.push_back(mkv(0, 2'b11, 2'b00, 2'b00, 0, 0, 20, 255, 2'b00, 49, 6, 2'b00, 2'b01));
      // limit = 0: every enabled edge is terminal, both directions
      vecs.push_back(mkv(0, 2'b01, 2'b01, 2'b00, 0, 0, 0, 255, 2'b00, 0, 6, 2'b01, 2'b01));
      vecs.push_back(mkv(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 255, 2'b00, 0, 6, 2'b01, 2'b01));
      // ch1 counts down through 0 and wraps to its limit
      vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b10, 0, 1, 0, 255, 2'b00, 0, 1, 2'b00, 2'b01));
      vecs.push_back(mkv(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 255, 2'b00, 0, 0, 2'b00, 2'b01));
      vecs.push_back(mkv(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 255, 2'b00, 0, 255, 2'b10, 2'b11));
      // Reset mid-count with load and en on all channels
      vecs.push_back(mkv(1, 2'b11, 2'b11, 2'b11, 77, 77, 255, 255, 2'b00, 0, 0, 2'b00, 2'b00));
      vecs.push_back(mkv(0, 2'b00, 2'b11, 2'b00, 0, 0, 255, 255, 2'b00, 0, 0, 2'b00, 2'b00));

      @(negedge clk);
      foreach (vecs[n]) begin
         a_reset = vecs[n].rst; a_en = vecs[n].en; a_dir = vecs[n].dir; a_load = vecs[n].ld;
         a_lv  = {vecs[n].lv1, vecs[n].lv0};
         a_lim = {vecs[n].lim1, vecs[n].lim0};
         a_clr = vecs[n].clr;
         @(posedge clk); #1;
         chk("count0",  n, a_count[7:0],  vecs[n].c0);
         chk("count1",  n, a_count[15:8], vecs[n].c1);
         chk("tc",      n, {6'd0, a_tc},  {6'd0, vecs[n].tc});
         chk("wrapped", n, {6'd0, a_wr},  {6'd0, vecs[n].wr});
      end

      // Saturating bank: hold at 0 going down, hold at limit going up
      b_step(0,  1, 0, 0, 0, 0, 5, 0, 0, 0, 0);
      b_step(1,  0, 1, 0, 1, 2, 5, 0, 2, 0, 0);
      b_step(2,  0, 1, 0, 0, 0, 5, 0, 1, 0, 0);
      b_step(3,  0, 1, 0, 0, 0, 5, 0, 0, 0, 0);
      b_step(4,  0, 1, 0, 0, 0, 5, 0, 0, 1, 1);
      b_step(5,  0, 1, 0, 0, 0, 5, 0, 0, 1, 1);
      b_step(6,  0, 1, 1, 0, 0, 5, 0, 1, 0, 1);
      b_step(7,  0, 0, 1, 1, 4, 5, 0, 4, 0, 1);
      b_step(8,  0, 1, 1, 0, 0, 5, 0, 5, 0, 1);
      b_step(9,  0, 1, 1, 0, 0, 5, 0, 5, 1, 1);
      b_step(10, 0, 1, 1, 0, 0, 5, 0, 5, 1, 1);
      b_step(11, 0, 0, 1, 0, 0, 5, 1, 5, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
